// File: rtl/oram_pkg.sv
// Shared types and helpers for the Path-ORAM controller: FSM encoding,
// LFSR polynomial and the root-to-leaf bucket index function.
package oram_pkg;

  localparam int LFSR_W = 16;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_READ   = 3'd2,
    S_UPDATE = 3'd3,
    S_WRITE  = 3'd4,
    S_RESP   = 3'd5
  } oram_state_e;

  // Bucket index of the node at `level` on the path to `leaf` in a tree of
  // depth `depth` (root is bucket 0, heap layout).
  function automatic int path_bucket(input int leaf, input int level, input int depth);
    return ((1 << level) - 1) + (leaf >> (depth - level));
  endfunction

endpackage

// File: rtl/path_oram_ctrl_if.sv
// Request/response bundle between a client and the Path-ORAM controller.
interface path_oram_ctrl_if #(
  parameter int A = 4,
  parameter int D = 3
);
  // A request transfers on a clock edge where req_valid && req_ready; the
  // client holds req_* stable until then. rsp_valid is a one-cycle pulse
  // with no back-pressure.
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [D-1:0]   req_addr;
  logic [8*A-1:0] req_wdata;
  logic           rsp_valid;
  logic [8*A-1:0] rsp_rdata;
  logic           stash_overflow;
  logic           busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, stash_overflow, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, stash_overflow, busy
  );
endinterface

// File: rtl/oram_lfsr.sv
// 16-bit Galois LFSR used to pick fresh leaves; exposes only the low bits.
module oram_lfsr
  import oram_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [OUT_W-1:0] value
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (adv) begin
      state_d = {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? LFSR_POLY : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value = state_q[OUT_W-1:0];

endmodule

// File: rtl/path_oram_ctrl.sv
// Path-ORAM controller: on-chip tree, position map and stash; each access
// reads and rewrites one full path and remaps the block to a new leaf.
module path_oram_ctrl
  import oram_pkg::*;
#(
  parameter int          A    = 4,
  parameter int          D    = 3,
  parameter int          K    = 2,
  parameter int          S    = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  path_oram_ctrl_if.slave   bus,
  output oram_state_e       dbg_state
);

  localparam int W  = 8 * A;
  localparam int NB = (1 << (D + 1)) - 1;
  localparam int NT = NB * K;
  localparam int N  = 1 << D;
  localparam int TW = $clog2(NT);
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int LW = $clog2(D + 1);
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef struct packed {
    logic [D-1:0] leaf;
    logic [D-1:0] blk;
    logic [W-1:0] val;
    logic         full;
  } tuple_t;

  oram_state_e  state_q, state_d;
  tuple_t       tree_q [NT];
  tuple_t       tree_d [NT];
  tuple_t       stash_q [S];
  tuple_t       stash_d [S];
  logic [D-1:0] posmap_leaf_q [N];
  logic [D-1:0] posmap_leaf_d [N];
  logic         posmap_wr_q [N];
  logic         posmap_wr_d [N];
  logic [D-1:0] addr_q, addr_d, old_leaf_q, old_leaf_d, new_leaf_q, new_leaf_d;
  logic [W-1:0] wdata_q, wdata_d, cap_q, cap_d, rsp_rdata_q, rsp_rdata_d;
  logic         write_q, write_d, was_wr_q, was_wr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [KW-1:0] slot_q, slot_d;
  logic         req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, ovf_q, ovf_d;

  logic         lfsr_adv;
  logic [D-1:0] lfsr_leaf;
  logic [TW-1:0] tree_idx;
  logic         slot_last;
  logic         free_found, match_found, evict_found;
  logic [SW-1:0] free_idx, match_idx, evict_idx;

  oram_lfsr #(.SEED(SEED), .OUT_W(D)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (lfsr_adv),
    .value (lfsr_leaf)
  );

  // Both READ and WRITE walk the path of the block's previous leaf.
  assign tree_idx  = TW'(path_bucket(int'(old_leaf_q), int'(lvl_q), D) * K + int'(slot_q));
  assign slot_last = (slot_q == KW'(K - 1));

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    evict_found = 1'b0;
    evict_idx   = '0;
    for (int i = S - 1; i >= 0; i--) begin
      if (!stash_q[i].full) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
      if (stash_q[i].full && (stash_q[i].blk == addr_q)) begin
        match_found = 1'b1;
        match_idx   = SW'(i);
      end
      if (stash_q[i].full &&
          ((int'(stash_q[i].leaf) >> (D - int'(lvl_q))) ==
           (int'(old_leaf_q) >> (D - int'(lvl_q))))) begin
        evict_found = 1'b1;
        evict_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    tree_d        = tree_q;
    stash_d       = stash_q;
    posmap_leaf_d = posmap_leaf_q;
    posmap_wr_d   = posmap_wr_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    old_leaf_d    = old_leaf_q;
    new_leaf_d    = new_leaf_q;
    was_wr_d      = was_wr_q;
    lvl_d         = lvl_q;
    slot_d        = slot_q;
    cap_d         = cap_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    ovf_d         = ovf_q;
    lfsr_adv      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          write_d     = bus.req_write;
          wdata_d     = bus.req_wdata;
          lfsr_adv    = 1'b1;
          req_ready_d = 1'b0;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        old_leaf_d            = posmap_leaf_q[addr_q];
        was_wr_d              = posmap_wr_q[addr_q];
        new_leaf_d            = lfsr_leaf;
        posmap_leaf_d[addr_q] = lfsr_leaf;
        posmap_wr_d[addr_q]   = 1'b1;
        lvl_d                 = '0;
        slot_d                = '0;
        state_d               = S_READ;
      end
      S_READ: begin
        if (tree_q[tree_idx].full) begin
          if (free_found) stash_d[free_idx] = tree_q[tree_idx];
          else            ovf_d = 1'b1;
        end
        tree_d[tree_idx] = '0;
        if (slot_last) begin
          slot_d = '0;
          lvl_d  = lvl_q + LW'(1);
          if (lvl_q == LW'(D)) state_d = S_UPDATE;
        end else begin
          slot_d = slot_q + KW'(1);
        end
      end
      S_UPDATE: begin
        if (match_found) begin
          cap_d = was_wr_q ? stash_q[match_idx].val : '0;
          if (write_q) stash_d[match_idx].val = wdata_q;
          stash_d[match_idx].leaf = new_leaf_q;
        end else begin
          cap_d = '0;
          if (write_q) begin
            if (free_found) begin
              stash_d[free_idx] = '{leaf: new_leaf_q, blk: addr_q, val: wdata_q, full: 1'b1};
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        lvl_d   = LW'(D);
        slot_d  = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (evict_found) begin
          tree_d[tree_idx]   = stash_q[evict_idx];
          stash_d[evict_idx] = '0;
        end else begin
          tree_d[tree_idx] = '0;
        end
        if (slot_last) begin
          slot_d = '0;
          if (lvl_q == '0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cap_q;
          end else begin
            lvl_d = lvl_q - LW'(1);
          end
        end else begin
          slot_d = slot_q + KW'(1);
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tree_q        <= '{default: '0};
      stash_q       <= '{default: '0};
      posmap_leaf_q <= '{default: '0};
      posmap_wr_q   <= '{default: 1'b0};
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      old_leaf_q    <= '0;
      new_leaf_q    <= '0;
      was_wr_q      <= 1'b0;
      lvl_q         <= '0;
      slot_q        <= '0;
      cap_q         <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tree_q        <= tree_d;
      stash_q       <= stash_d;
      posmap_leaf_q <= posmap_leaf_d;
      posmap_wr_q   <= posmap_wr_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      old_leaf_q    <= old_leaf_d;
      new_leaf_q    <= new_leaf_d;
      was_wr_q      <= was_wr_d;
      lvl_q         <= lvl_d;
      slot_q        <= slot_d;
      cap_q         <= cap_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.busy           = !req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.stash_overflow = ovf_q;
  assign dbg_state          = state_q;

endmodule
